// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the instruction-cache line-refill engine.
// The constants describe the default geometry (512-bit line, 64-bit beats).
package icache_refill_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMreq  = 2'd1,
        StBeats = 2'd2,
        StResp  = 2'd3
    } refill_state_t;

    localparam int unsigned DEFAULT_LINE_WIDTH = 512;
    localparam int unsigned DEFAULT_BEAT_WIDTH = 64;
    localparam int unsigned BEATS_PER_LINE     = DEFAULT_LINE_WIDTH / DEFAULT_BEAT_WIDTH;
    localparam int unsigned CNT_BITS           = $clog2(BEATS_PER_LINE);
    localparam int unsigned LINE_OFFSET_BITS   = $clog2(DEFAULT_LINE_WIDTH / 8);

    // Zero the byte-offset bits of an address so it points at the start of its line.
    function automatic logic [63:0] line_align(input logic [63:0] paddr,
                                               input int unsigned off_bits);
        logic [63:0] mask;
        mask = ~((64'd1 << off_bits) - 64'd1);
        return paddr & mask;
    endfunction

endpackage

// File: rtl/icache_refill_assembler.sv
// Beat counter plus line register: drops each accepted memory beat into the line slot
// selected by the counter. The counter wraps after the last beat so the next refill
// starts from slot 0.
module icache_refill_assembler
    import icache_refill_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned BEAT_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic                  beat_en_i,
    input  logic [BEAT_WIDTH-1:0] beat_data_i,
    output logic                  last_o,
    output logic [LINE_WIDTH-1:0] data_o
);

    localparam int unsigned Beats   = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CntBits = $clog2(Beats);

    logic [CntBits-1:0]    cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;

    // Next counter value and line contents for an accepted beat.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (beat_en_i) begin
            cnt_d = cnt_q + 1'b1;
            for (int unsigned i = 0; i < Beats; i++) begin
                if (cnt_q == i[CntBits-1:0]) begin
                    data_d[i*BEAT_WIDTH +: BEAT_WIDTH] = beat_data_i;
                end
            end
        end
    end

    // Counter and line storage.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign last_o = (cnt_q == CntBits'(Beats - 1));
    assign data_o = data_q;

endmodule

// File: rtl/icache_refill_unit.sv
// Instruction-cache line-refill engine: takes one line miss, issues a line-aligned memory
// read, assembles the returned beats and hands the line back with a one-cycle valid/ack.
// Coherence invalidations are registered onto the fill-response port.
// Optional feature macro ICACHE_REFILL_PMU_EN adds busy/abort performance-monitor outputs.
module icache_refill_unit
    import icache_refill_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned BEAT_WIDTH = 64,
    parameter int unsigned PADDR_SIZE = 40,
    parameter int unsigned WAY_BITS   = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    input  logic [WAY_BITS-1:0]   req_way_i,
    input  logic [PADDR_SIZE-1:0] req_paddr_i,
    output logic                  resp_valid_o,
    output logic                  resp_ack_o,
    output logic [WAY_BITS-1:0]   resp_way_o,
    output logic [LINE_WIDTH-1:0] resp_data_o,
    output logic                  resp_inv_valid_o,
    output logic [PADDR_SIZE-1:0] resp_inv_paddr_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PADDR_SIZE-1:0] mem_req_paddr_o,
    input  logic                  mem_beat_valid_i,
    input  logic [BEAT_WIDTH-1:0] mem_beat_data_i,
`ifdef ICACHE_REFILL_PMU_EN
    output logic                  refill_busy_pmu_o,
    output logic                  refill_abort_pmu_o,
`endif
    input  logic                  inv_valid_i,
    input  logic [PADDR_SIZE-1:0] inv_paddr_i
);

    localparam int unsigned LineOffBits = $clog2(LINE_WIDTH / 8);

    refill_state_t         state_q, state_d;
    logic                  abort_q, abort_d;
    logic [WAY_BITS-1:0]   way_q;
    logic [PADDR_SIZE-1:0] paddr_q;
    logic                  inv_valid_q;
    logic [PADDR_SIZE-1:0] inv_paddr_q;
    logic                  capture;
    logic                  cnt_clr;
    logic                  beat_en;
    logic                  beat_last;
`ifdef ICACHE_REFILL_PMU_EN
    logic                  abort_pulse_q, abort_pulse_d;
`endif

    // Byte-offset bits of the miss address are dropped by line alignment.
    logic unused_paddr_lsb;
    assign unused_paddr_lsb = ^req_paddr_i[LineOffBits-1:0];

    assign beat_en = (state_q == StBeats) && mem_beat_valid_i;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, request capture, counter clear and sticky abort tracking.
    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        capture = 1'b0;
        cnt_clr = 1'b0;
`ifdef ICACHE_REFILL_PMU_EN
        abort_pulse_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && !flush_i) begin
                    capture = 1'b1;
                    state_d = StMreq;
                end
            end
            StMreq: begin
                // Flush wins over a same-cycle ready.
                if (flush_i) begin
                    state_d = StIdle;
                end else if (mem_req_ready_i) begin
                    cnt_clr = 1'b1;
                    state_d = StBeats;
                end
            end
            StBeats: begin
                if (flush_i) begin
                    abort_d = 1'b1;
                end
                // The read is already in flight, so an aborted refill still drains all beats.
                if (mem_beat_valid_i && beat_last) begin
                    abort_d = 1'b0;
                    if (abort_q || flush_i) begin
                        state_d = StIdle;
`ifdef ICACHE_REFILL_PMU_EN
                        abort_pulse_d = 1'b1;
`endif
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Captured request, abort flag and registered invalidation.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            abort_q     <= 1'b0;
            way_q       <= '0;
            paddr_q     <= '0;
            inv_valid_q <= 1'b0;
            inv_paddr_q <= '0;
        end else begin
            abort_q     <= abort_d;
            inv_valid_q <= inv_valid_i;
            inv_paddr_q <= inv_paddr_i;
            if (capture) begin
                way_q   <= req_way_i;
                paddr_q <= {req_paddr_i[PADDR_SIZE-1:LineOffBits], {LineOffBits{1'b0}}};
            end
        end
    end

    icache_refill_assembler #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_assembler (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clr_i       (cnt_clr),
        .beat_en_i   (beat_en),
        .beat_data_i (mem_beat_data_i),
        .last_o      (beat_last),
        .data_o      (resp_data_o)
    );

    assign resp_valid_o     = (state_q == StResp);
    assign resp_ack_o       = (state_q == StResp);
    assign resp_way_o       = way_q;
    assign resp_inv_valid_o = inv_valid_q;
    assign resp_inv_paddr_o = inv_paddr_q;
    assign mem_req_valid_o  = (state_q == StMreq);
    assign mem_req_paddr_o  = paddr_q;

`ifdef ICACHE_REFILL_PMU_EN
    // One-cycle pulse as an aborted refill lands back in idle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            abort_pulse_q <= 1'b0;
        end else begin
            abort_pulse_q <= abort_pulse_d;
        end
    end

    assign refill_busy_pmu_o  = (state_q != StIdle);
    assign refill_abort_pmu_o = abort_pulse_q;
`endif

endmodule
